// File: rtl/arbiter_wrr_pkg.sv
// Shared definitions for the weighted round-robin arbiter: FSM state encoding
// and the width helper used to size grant_id.
package arbiter_wrr_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int arb_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request bit
// at or after index 'start', wrapping modulo NUM_PORTS.
module arbiter_rr_pick #(
  parameter int NUM_PORTS = 6,
  parameter int ID_W      = 3
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [ID_W-1:0]      start,
  output logic                 found,
  output logic [ID_W-1:0]      pick_idx,
  output logic [NUM_PORTS-1:0] pick_onehot
);

  localparam int DW = 2 * NUM_PORTS;

  logic [DW-1:0] dbl_req;
  logic [DW-1:0] keep_mask;
  logic [DW-1:0] masked;

  // The upper copy covers the wrapped part of the scan, so the lowest set bit
  // of the masked double-width vector is the rotating-priority winner.
  assign dbl_req   = {request, request};
  assign keep_mask = ~((DW'(1) << start) - DW'(1));
  assign masked    = dbl_req & keep_mask;

  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (masked[i]) begin
        found    = 1'b1;
        pick_idx = (i >= NUM_PORTS) ? ID_W'(i - NUM_PORTS) : ID_W'(i);
      end
    end
  end

  assign pick_onehot = found ? (NUM_PORTS'(1) << pick_idx) : '0;

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: the owner keeps a registered grant for up to
// its weight in consecutive cycles, then ownership rotates to the next requester.
module arbiter_wrr
  import arbiter_wrr_pkg::*;
#(
  parameter int NUM_PORTS = 6,
  parameter int WEIGHT_W  = 4,
  parameter int ID_W      = arb_clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          request,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [ID_W-1:0]               grant_id,
  output logic                          active,
  output logic                          quota_end
);

  arb_state_e           state, state_next;
  logic [WEIGHT_W-1:0]  cnt, cnt_next;
  logic [ID_W-1:0]      last, last_next;
  logic [ID_W-1:0]      grant_id_next;
  logic [NUM_PORTS-1:0] grant_next;
  logic                 quota_end_next;

  logic [ID_W-1:0]      start_idx;
  logic                 found;
  logic [ID_W-1:0]      pick_idx;
  logic [NUM_PORTS-1:0] pick_onehot;
  logic [WEIGHT_W-1:0]  pick_weight;
  logic                 rearb;

  assign start_idx   = (last == ID_W'(NUM_PORTS - 1)) ? '0 : last + ID_W'(1);
  assign pick_weight = weight[pick_idx*WEIGHT_W +: WEIGHT_W];

  arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ID_W      (ID_W)
  ) u_pick (
    .request     (request),
    .start       (start_idx),
    .found       (found),
    .pick_idx    (pick_idx),
    .pick_onehot (pick_onehot)
  );

  // Tenure ends on early release or an exhausted count; rearbitration happens
  // on that same edge so handovers never leave an idle cycle.
  assign rearb = (state == ARB_IDLE) || !request[grant_id] || (cnt == '0);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    last_next     = last;
    grant_next    = grant;
    grant_id_next = grant_id;
    if (rearb) begin
      if (found) begin
        state_next    = ARB_GRANT;
        grant_next    = pick_onehot;
        grant_id_next = pick_idx;
        last_next     = pick_idx;
        cnt_next      = (pick_weight == '0) ? '0 : pick_weight - WEIGHT_W'(1);
      end else begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    end else begin
      cnt_next = cnt - WEIGHT_W'(1);
    end
    quota_end_next = (state_next == ARB_GRANT) && (cnt_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      last      <= ID_W'(NUM_PORTS - 1);
      grant     <= '0;
      grant_id  <= '0;
      quota_end <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      last      <= last_next;
      grant     <= grant_next;
      grant_id  <= grant_id_next;
      quota_end <= quota_end_next;
    end
  end

  assign active = |grant;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Self-checking bench for arbiter_wrr: directed scenarios plus randomized
// traffic compared against a tenure-level reference model.
module tb_arbiter_wrr;

  localparam int N  = 6;
  localparam int WW = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    request;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_id;
  logic            active;
  logic            quota_end;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the resource and how many owned cycles remain.
  bit m_active;
  int m_owner;
  int m_left;
  int m_last;

  always #5 clk = ~clk;

  arbiter_wrr #(
    .NUM_PORTS (N),
    .WEIGHT_W  (WW),
    .ID_W      (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .request   (request),
    .weight    (weight),
    .grant     (grant),
    .grant_id  (grant_id),
    .active    (active),
    .quota_end (quota_end)
  );

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] one;
    one = 1;
    return m_active ? (one << m_owner) : '0;
  endfunction

  task automatic set_weight(input int p, input int w);
    weight[p*WW +: WW] = WW'(w);
  endtask

  // Advance one clock edge, update the model from the inputs sampled there,
  // and return 1 time unit later so outputs can be compared.
  task automatic tick();
    int q;
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
      m_last   = N - 1;
    end else if (!m_active || !request[m_owner] || m_left == 1) begin
      m_active = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (!m_active && request[p]) begin
          m_active = 1'b1;
          m_owner  = p;
          m_last   = p;
          q        = int'(weight[p*WW +: WW]);
          m_left   = (q == 0) ? 1 : q;
        end
      end
    end else begin
      m_left--;
    end
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    request = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    request = '1;
    weight  = $urandom;
    tick();
    tick();
    tests++; if (grant !== 6'b0) begin fails++; $display("[TB] FAIL reset_grant got %b want %b", grant, 6'b0); end
    tests++; if (grant_id !== 3'd0) begin fails++; $display("[TB] FAIL reset_grant_id got %0d want 0", grant_id); end
    tests++; if (active !== 1'b0) begin fails++; $display("[TB] FAIL reset_active got %b want 0", active); end
    tests++; if (quota_end !== 1'b0) begin fails++; $display("[TB] FAIL reset_quota_end got %b want 0", quota_end); end
    rst = 1'b0;
  endtask

  task automatic test_sole_requester();
    do_reset();
    set_weight(0, 3);
    request = 6'b000001;
    for (int c = 0; c < 7; c++) begin
      tick();
      tests++; if (grant !== 6'b000001) begin fails++; $display("[TB] FAIL sole_grant cyc%0d got %b want %b", c, grant, 6'b000001); end
      tests++; if (quota_end !== (c % 3 == 2)) begin fails++; $display("[TB] FAIL sole_quota_end cyc%0d got %b want %b", c, quota_end, (c % 3 == 2)); end
    end
  endtask

  task automatic test_two_port_weights();
    int exp_id;
    do_reset();
    set_weight(0, 2);
    set_weight(2, 3);
    request = 6'b000101;
    for (int c = 0; c < 12; c++) begin
      tick();
      exp_id = (c % 5 < 2) ? 0 : 2;
      tests++; if (!active || grant_id !== IW'(exp_id)) begin fails++; $display("[TB] FAIL two_port_id cyc%0d got %0d/%b want %0d/1", c, grant_id, active, exp_id); end
      tests++; if (quota_end !== (c % 5 == 1 || c % 5 == 4)) begin fails++; $display("[TB] FAIL two_port_quota_end cyc%0d got %b", c, quota_end); end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    set_weight(1, 8);
    set_weight(4, 2);
    request = 6'b000010;
    tick();
    tick();
    tests++; if (grant !== 6'b000010) begin fails++; $display("[TB] FAIL release_owner1 got %b want %b", grant, 6'b000010); end
    request = 6'b010000;
    tick();
    tests++; if (grant !== 6'b010000) begin fails++; $display("[TB] FAIL release_handover got %b want %b", grant, 6'b010000); end
    request = 6'b010010;
    tick();
    tests++; if (grant !== 6'b010000 || quota_end !== 1'b1) begin fails++; $display("[TB] FAIL release_port4_hold got %b qe=%b want %b qe=1", grant, quota_end, 6'b010000); end
    tick();
    tests++; if (grant !== 6'b000010) begin fails++; $display("[TB] FAIL release_back_to_1 got %b want %b", grant, 6'b000010); end
  endtask

  task automatic test_all_ones_rotation();
    logic [N-1:0] one;
    one = 1;
    do_reset();
    for (int p = 0; p < N; p++) set_weight(p, 1);
    request = '1;
    for (int c = 0; c < 8; c++) begin
      tick();
      tests++; if (grant !== (one << (c % N)) || grant_id !== IW'(c % N)) begin fails++; $display("[TB] FAIL rotate cyc%0d got %b/%0d want %b", c, grant, grant_id, one << (c % N)); end
      tests++; if (quota_end !== 1'b1) begin fails++; $display("[TB] FAIL rotate_quota_end cyc%0d got %b want 1", c, quota_end); end
    end
  endtask

  task automatic test_zero_weight();
    do_reset();
    set_weight(3, 0);
    request = 6'b001000;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++; if (grant !== 6'b001000 || quota_end !== 1'b1) begin fails++; $display("[TB] FAIL zero_weight cyc%0d got %b qe=%b want %b qe=1", c, grant, quota_end, 6'b001000); end
    end
  endtask

  task automatic test_reset_mid_tenure();
    do_reset();
    set_weight(2, 8);
    request = 6'b000100;
    tick();
    tick();
    tick();
    tests++; if (grant_id !== 3'd2 || quota_end !== 1'b0) begin fails++; $display("[TB] FAIL mid_owner got %0d qe=%b want 2 qe=0", grant_id, quota_end); end
    rst = 1'b1;
    tick();
    tests++; if (grant !== 6'b0 || active !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset got %b act=%b want 0", grant, active); end
    rst     = 1'b0;
    request = '1;
    tick();
    tests++; if (grant !== 6'b000001) begin fails++; $display("[TB] FAIL mid_restart got %b want %b", grant, 6'b000001); end
  endtask

  task automatic test_random();
    do_reset();
    weight = $urandom;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) request = N'($urandom);
      if ($urandom_range(7) == 0) set_weight($urandom_range(N - 1), $urandom_range(15));
      tick();
      tests++; if (grant !== exp_grant() || active !== m_active) begin fails++; $display("[TB] FAIL rand_grant cyc%0d got %b act=%b want %b act=%b", c, grant, active, exp_grant(), m_active); end
      tests++; if (quota_end !== (m_active && m_left == 1)) begin fails++; $display("[TB] FAIL rand_quota_end cyc%0d got %b want %b", c, quota_end, (m_active && m_left == 1)); end
      if (m_active) begin
        tests++; if (grant_id !== IW'(m_owner)) begin fails++; $display("[TB] FAIL rand_grant_id cyc%0d got %0d want %0d", c, grant_id, m_owner); end
      end
      tests++; if ($countones(grant) > 1) begin fails++; $display("[TB] FAIL rand_onehot cyc%0d got %b want <=1 bit", c, grant); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    request  = '0;
    weight   = '0;
    m_active = 1'b0;
    m_owner  = 0;
    m_left   = 0;
    m_last   = N - 1;
    test_reset();
    test_sole_requester();
    test_two_port_weights();
    test_early_release();
    test_all_ones_rotation();
    test_zero_weight();
    test_reset_mid_tenure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
